fpow: RTL and testbench

FPOW -- requirements
Module: fpow

---
 rtl/fpow.sv | 180 ++++++++++++++++++
 tb/tb_fpow.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpow.sv
// Floating-point power unit: raises an IEEE754 single base to a small
// non-negative integer exponent with a multi-cycle square-and-multiply loop.
module fpow (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] ONE     = 32'h3F80_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  // Magnitude product of two normal operands, truncated.
  // Returns {ovf, unf, magnitude}.
  function automatic logic [33:0] mag_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0]        prod;
    logic signed [10:0] exp_sum;
    logic [22:0]        frac;
    prod    = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    exp_sum = $signed({3'd0, x[30:23]}) + $signed({3'd0, y[30:23]}) - 11'sd127
              + (prod[47] ? 11'sd1 : 11'sd0);
    frac    = prod[47] ? prod[46:24] : prod[45:23];
    mag_mul = {(exp_sum >= 11'sd255), (exp_sum <= 11'sd0), 1'b0, exp_sum[7:0], frac};
  endfunction

  state_t      state_r, next_s;
  logic [31:0] a_r, b_r, acc_r, base_r, result_r;
  logic [7:0]  n_r;
  logic        sign_r, overflow_r, underflow_r, busy_r, done_r;

  logic        a_nan_s, a_inf_s, a_zero_s, b_nan_s, b_zero_s, b_int_s;
  logic [7:0]  shift_s;
  logic [23:0] b_mant_s, mask_s, n_full_s;
  logic        dec_sign_s, dec_special_s;
  logic [31:0] dec_result_s;
  logic [31:0] mul_x_s, mul_mag_s;
  logic [33:0] mul_s;
  logic        mul_ovf_s, mul_unf_s;

  assign a_nan_s    = (a_r[30:23] == 8'hFF) && (a_r[22:0] != 23'd0);
  assign a_inf_s    = (a_r[30:23] == 8'hFF) && (a_r[22:0] == 23'd0);
  assign a_zero_s   = (a_r[30:23] == 8'h00);
  assign b_nan_s    = (b_r[30:23] == 8'hFF) && (b_r[22:0] != 23'd0);
  assign b_zero_s   = (b_r[30:0] == 31'd0);
  assign b_mant_s   = {1'b1, b_r[22:0]};
  assign shift_s    = 8'd150 - b_r[30:23];
  assign mask_s     = (24'd1 << shift_s) - 24'd1;
  assign n_full_s   = b_mant_s >> shift_s;
  // Integer exponent 1..255: exponent field 127..134 with no fractional bits.
  assign b_int_s    = !b_r[31] && (b_r[30:23] >= 8'd127) && (b_r[30:23] <= 8'd134)
                      && ((b_mant_s & mask_s) == 24'd0) && (n_full_s[23:8] == 16'd0);
  assign dec_sign_s = a_r[31] & n_full_s[0];

  // Special-case classification in priority order.
  always_comb begin
    dec_special_s = 1'b1;
    dec_result_s  = QNAN;
    if (a_nan_s || b_nan_s) begin
      dec_result_s = QNAN;
    end else if (!b_zero_s && !b_int_s) begin
      dec_result_s = QNAN;
    end else if (b_zero_s) begin
      dec_result_s = ONE;
    end else if (a_inf_s) begin
      dec_result_s = {dec_sign_s, INF_MAG};
    end else if (a_zero_s) begin
      dec_result_s = {dec_sign_s, 31'd0};
    end else begin
      dec_special_s = 1'b0;
      dec_result_s  = ONE;
    end
  end

  assign mul_x_s   = n_r[0] ? acc_r : base_r;
  assign mul_s     = mag_mul(mul_x_s, base_r);
  assign mul_ovf_s = mul_s[33];
  assign mul_unf_s = mul_s[32];
  assign mul_mag_s = mul_s[31:0];

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:    if (START) next_s = DECODE; else next_s = IDLE;
      DECODE:  if (dec_special_s) next_s = DONE; else next_s = RUN;
      RUN:     if ((n_r == 8'd0) || mul_ovf_s || mul_unf_s) next_s = DONE; else next_s = RUN;
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      busy_r  <= (next_s != IDLE);
      done_r  <= (next_s == DONE);
    end
  end

  // Operand capture, square-and-multiply datapath and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      acc_r       <= 32'd0;
      base_r      <= 32'd0;
      n_r         <= 8'd0;
      sign_r      <= 1'b0;
      result_r    <= 32'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (START) begin
            a_r         <= A;
            b_r         <= B;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
          end
        end
        DECODE: begin
          if (dec_special_s) begin
            result_r <= dec_result_s;
          end else begin
            acc_r  <= ONE;
            base_r <= {1'b0, a_r[30:0]};
            n_r    <= n_full_s[7:0];
            sign_r <= dec_sign_s;
          end
        end
        RUN: begin
          if (n_r == 8'd0) begin
            result_r <= {sign_r, acc_r[30:0]};
          end else if (mul_ovf_s) begin
            overflow_r <= 1'b1;
            result_r   <= {sign_r, INF_MAG};
          end else if (mul_unf_s) begin
            underflow_r <= 1'b1;
            result_r    <= {sign_r, 31'd0};
          end else if (n_r[0]) begin
            acc_r <= mul_mag_s;
            n_r   <= {n_r[7:1], 1'b0};
          end else begin
            base_r <= mul_mag_s;
            n_r    <= {1'b0, n_r[7:1]};
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

  assign result    = result_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_fpow.sv
// Self-checking bench for fpow: directed vector table, corner-case sequences,
// and randomized operations checked against a value-level reference model.
module tb_fpow;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] result;
  logic        overflow, underflow, busy, done;

  int n_checks = 0;
  int n_pass   = 0;

  fpow dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .result(result), .overflow(overflow), .underflow(underflow),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    logic        u;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Multiply two (biased exponent, 24-bit mantissa) values, truncating.
  function automatic void fmul(inout int e, inout longint m, input int e2, input longint m2);
    longint p;
    p = m * m2;
    e = e + e2 - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      p = p >> 1;
      e = e + 1;
    end
    m = p >> 23;
  endfunction

  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic o,
                                    output logic u, output int lat);
    int     ae, be, sh, nval, msb, ops, acce, bse;
    longint bm, accm, bsm;
    logic   valid, bzero, sgn;
    ae = int'(a[30:23]);
    be = int'(b[30:23]);
    o = 1'b0; u = 1'b0; lat = 1; nval = 0; valid = 1'b0;
    bzero = (b[30:0] == 31'd0);
    if (!bzero && !b[31] && be >= 127 && be <= 134) begin
      sh    = 150 - be;
      bm    = longint'({1'b1, b[22:0]});
      nval  = int'(bm >> sh);
      valid = ((longint'(nval) << sh) == bm);
    end
    sgn = a[31] & nval[0];
    if ((ae == 255 && a[22:0] != 0) || (be == 255 && b[22:0] != 0)) r = 32'h7FC0_0000;
    else if (!bzero && !valid) r = 32'h7FC0_0000;
    else if (bzero) r = 32'h3F80_0000;
    else if (ae == 255) r = {sgn, 31'h7F80_0000};
    else if (ae == 0) r = {sgn, 31'd0};
    else begin
      msb = 0;
      for (int i = 0; i < 8; i++) if (nval[i]) msb = i;
      acce = 127; accm = 64'd1 << 23;
      bse = ae; bsm = longint'({1'b1, a[22:0]});
      ops = 0;
      for (int i = 0; i <= msb; i++) begin
        if (nval[i]) begin
          ops++;
          fmul(acce, accm, bse, bsm);
          if (acce >= 255) begin o = 1'b1; r = {sgn, 31'h7F80_0000}; lat = 1 + ops; return; end
          if (acce <= 0)   begin u = 1'b1; r = {sgn, 31'd0};         lat = 1 + ops; return; end
        end
        if (i < msb) begin
          ops++;
          fmul(bse, bsm, bse, bsm);
          if (bse >= 255) begin o = 1'b1; r = {sgn, 31'h7F80_0000}; lat = 1 + ops; return; end
          if (bse <= 0)   begin u = 1'b1; r = {sgn, 31'd0};         lat = 1 + ops; return; end
        end
      end
      r   = {sgn, acce[7:0], accm[22:0]};
      lat = ops + 2;
    end
  endfunction

  function automatic logic [31:0] int_to_f(input int n);
    int         k;
    logic [7:0] e8;
    int         f;
    k = 0;
    for (int i = 0; i < 8; i++) if (n[i]) k = i;
    e8 = 8'(127 + k);
    f  = (n << (23 - k)) & 32'h007F_FFFF;
    return {1'b0, e8, f[22:0]};
  endfunction

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo, input logic eu, input int el);
    int lat;
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; A = $urandom; B = $urandom;
    check({nm, ".busy"}, {31'd0, busy}, 32'd1);
    check({nm, ".flags_clr"}, {30'd0, overflow, underflow}, 32'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    check({nm, ".result"}, result, er);
    check({nm, ".ovf_unf"}, {30'd0, overflow, underflow}, {30'd0, eo, eu});
    check({nm, ".latency"}, lat, el);
    @(posedge CLK); #1;
    check({nm, ".done_pulse"}, {31'd0, done}, 32'd0);
    check({nm, ".hold"}, {overflow, underflow, result[29:0]}, {eo, eu, er[29:0]});
    check({nm, ".idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rr, cap;
    logic        ro, ru;
    int          rl, dones;

    vecs[0]  = '{32'h40400000, 32'h40000000, 32'h41100000, 1'b0, 1'b0, 4};
    vecs[1]  = '{32'hC0000000, 32'h40400000, 32'hC1000000, 1'b0, 1'b0, 5};
    vecs[2]  = '{32'hC0000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0, 4};
    vecs[3]  = '{32'h40000000, 32'h437F0000, 32'h7F800000, 1'b1, 1'b0, 15};
    vecs[4]  = '{32'h3F000000, 32'h43480000, 32'h00000000, 1'b0, 1'b1, 10};
    vecs[5]  = '{32'h40000000, 32'h40200000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[6]  = '{32'h40000000, 32'hBF800000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[7]  = '{32'h40000000, 32'h7FC00001, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[8]  = '{32'h7F800000, 32'h00000000, 32'h3F800000, 1'b0, 1'b0, 1};
    vecs[9]  = '{32'h00000000, 32'h00000000, 32'h3F800000, 1'b0, 1'b0, 1};
    vecs[10] = '{32'hFF800000, 32'h40400000, 32'hFF800000, 1'b0, 1'b0, 1};
    vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1};
    vecs[12] = '{32'h00000001, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[13] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b0, 1'b0, 3};
    vecs[14] = '{32'h40400000, 32'h43800000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[15] = '{32'h40400000, 32'h80000000, 32'h3F800000, 1'b0, 1'b0, 1};
    vecs[16] = '{32'h7FC00000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0, 1};
    vecs[17] = '{32'hBFC00000, 32'h40000000, 32'h40100000, 1'b0, 1'b0, 4};

    repeat (3) @(posedge CLK);
    #1;
    check("reset.outputs", {result[29:0], overflow, underflow}, 32'd0);
    check("reset.busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge CLK); RST = 1'b0;

    for (int i = 0; i < 18; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].o, vecs[i].u, vecs[i].lat);

    // Reset mid-operation: abort without a done pulse, then start fresh.
    do_op("pre_rst", 32'h40400000, 32'h40000000, 32'h41100000, 1'b0, 1'b0, 4);
    @(negedge CLK); A = 32'h40000000; B = 32'h437F0000; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_run.result", result, 32'd0);
    check("rst_run.flags_busy_done", {28'd0, overflow, underflow, busy, done}, 32'd0);
    @(negedge CLK); RST = 1'b0;
    dones = 0;
    repeat (20) begin @(posedge CLK); #1; if (done === 1'b1) dones++; end
    check("rst_run.no_done", dones, 0);
    do_op("post_rst", 32'h40400000, 32'h40000000, 32'h41100000, 1'b0, 1'b0, 4);

    // Second START while busy is ignored.
    @(negedge CLK); A = 32'h40400000; B = 32'h40000000; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    @(negedge CLK); A = 32'h40000000; B = 32'h40000000; START = 1'b1;
    @(posedge CLK); #1; START = 1'b0;
    dones = 0; cap = 32'd0;
    repeat (25) begin
      @(posedge CLK); #1;
      if (done === 1'b1) begin dones++; cap = result; end
    end
    check("busy_start.dones", dones, 1);
    check("busy_start.result", cap, 32'h41100000);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 15) != 0) ra[30:23] = 8'($urandom_range(112, 142));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: rb = int_to_f(int'($urandom_range(1, 24)));
        7:                   rb = int_to_f(int'($urandom_range(1, 255)));
        default:             rb = $urandom;
      endcase
      ref_model(ra, rb, rr, ro, ru, rl);
      do_op($sformatf("rnd%0d", i), ra, rb, rr, ro, ru, rl);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
